// File: rtl/rand_buff_pkg.sv
// Shared constants and helpers for the random-word source and its consumers.
package rand_buff_pkg;

   localparam int          RAND_W    = 32;
   localparam int          XS_A      = 13;
   localparam int          XS_B      = 17;
   localparam int          XS_C      = 5;
   localparam logic [31:0] SEED_STEP = 32'h9E3779B9;

   // One xorshift32 step; shifts truncate to 32 bits.
   function automatic logic [RAND_W-1:0] xs_next(input logic [RAND_W-1:0] x);
      logic [RAND_W-1:0] t;
      t = x ^ (x << XS_A);
      t = t ^ (t >> XS_B);
      t = t ^ (t << XS_C);
      return t;
   endfunction

   // The all-zero state is a fixed point of xorshift, so it is replaced by 1.
   function automatic logic [RAND_W-1:0] fix_seed(input logic [RAND_W-1:0] s);
      return (s == '0) ? RAND_W'(1) : s;
   endfunction

endpackage

// File: rtl/rand_buff_port.sv
// One output port: xorshift32 generator feeding a DEPTH-word FIFO.
module rand_buff_port
   import rand_buff_pkg::*;
#(
   parameter int                DEPTH = 4,
   parameter logic [RAND_W-1:0] SEED  = 32'h2545F491
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              gen_en,
   input  logic              seed_load,
   input  logic [RAND_W-1:0] seed_in,
   input  logic              rd,
   output logic              ready,
   output logic [RAND_W-1:0] data,
   output logic              uflow
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam int               CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic [RAND_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [RAND_W-1:0] x;
   logic              push;
   logic              pop;

   // Decode push/pop/underflow from the registered count and this cycle's controls.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
      push  = 1'b0;
      pop   = 1'b0;
      uflow = 1'b0;
      if (!seed_load) begin
         pop   = rd && (count != '0);
         push  = gen_en && ((count < FULL) || pop);
         uflow = rd && (count == '0);
      end
   end

   // Pointer, count and generator state; seed_load flushes and reseeds.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         x      <= fix_seed(SEED);
      end else if (seed_load) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         x      <= fix_seed(seed_in);
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            x      <= xs_next(x);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // FIFO storage write; the current generator word is captured on a push.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; empty entries are never visible because data is gated by count.
      if (push) begin
         mem[wr_ptr] <= x;
      end
   end

   assign ready = (count != '0);
   assign data  = ready ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rand_buff.sv
// Random-word source: PARA_SIZE independent generator+FIFO ports with a shared sticky underflow flag.
module rand_buff
   import rand_buff_pkg::*;
#(
   parameter int          PARA_SIZE = 4,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] SEED_BASE = 32'h2545F491
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        gen_en,
   input  logic                        seed_load,
   input  logic [RAND_W*PARA_SIZE-1:0] seed_in,
   input  logic [PARA_SIZE-1:0]        rand_rd,
   output logic [PARA_SIZE-1:0]        rand_ready,
   output logic [RAND_W*PARA_SIZE-1:0] rand_data,
   output logic                        underflow
);

   logic [PARA_SIZE-1:0] uflow;

   for (genvar k = 0; k < PARA_SIZE; k++) begin : g_port
      localparam logic [RAND_W-1:0] SEED_K = fix_seed(SEED_BASE + RAND_W'(k) * SEED_STEP);

      rand_buff_port #(
         .DEPTH (DEPTH),
         .SEED  (SEED_K)
      ) u_port (
         .clk       (clk),
         .rstn      (rstn),
         .gen_en    (gen_en),
         .seed_load (seed_load),
         .seed_in   (seed_in[RAND_W*k +: RAND_W]),
         .rd        (rand_rd[k]),
         .ready     (rand_ready[k]),
         .data      (rand_data[RAND_W*k +: RAND_W]),
         .uflow     (uflow[k])
      );
   end

   // Sticky underflow: set by any port's empty read, cleared by seed_load.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         underflow <= 1'b0;
      end else if (seed_load) begin
         underflow <= 1'b0;
      end else if (|uflow) begin
         underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rand_buff.sv
// Scoreboard bench for rand_buff: expected word streams are queued per port when a seed
// takes effect and popped as the bench reads each word.
module tb_rand_buff;

   localparam int P = 4;

   logic          clk;
   logic          rstn;
   logic          gen_en;
   logic          seed_load;
   logic [32*P-1:0] seed_in;
   logic [P-1:0]  rand_rd;
   logic [P-1:0]  rand_ready;
   logic [32*P-1:0] rand_data;
   logic          underflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q [P][$];

   rand_buff #(.PARA_SIZE(P), .DEPTH(4), .SEED_BASE(32'h2545F491)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .gen_en     (gen_en),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .rand_rd    (rand_rd),
      .rand_ready (rand_ready),
      .rand_data  (rand_data),
      .underflow  (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_xs(input logic [31:0] v);
      logic [31:0] a;
      a = v ^ {v[18:0], 13'b0};
      a = a ^ {17'b0, a[31:17]};
      a = a ^ {a[26:0], 5'b0};
      return a;
   endfunction

   function automatic logic [31:0] reset_seed(input int k);
      logic [31:0] s;
      s = 32'h2545F491 + 32'(k) * 32'h9E3779B9;
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   task automatic load_model(input int k, input logic [31:0] seed);
      logic [31:0] v;
      v = (seed == 32'h0) ? 32'h1 : seed;
      exp_q[k].delete();
      for (int i = 0; i < 64; i++) begin
         exp_q[k].push_back(v);
         v = ref_xs(v);
      end
   endtask

   function automatic logic [31:0] data_of(input int k);
      return rand_data[32*k +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare head words of selected ports against the scoreboard, then pop them.
   task automatic pop_cycle(input logic [P-1:0] mask, input string tag);
      for (int k = 0; k < P; k++) begin
         if (mask[k]) begin
            check($sformatf("%s_rdy%0d", tag, k), 32'(rand_ready[k]), 32'h1);
            check($sformatf("%s_dat%0d", tag, k), data_of(k), exp_q[k].pop_front());
         end
      end
      rand_rd = mask;
      tick();
      rand_rd = '0;
   endtask

   initial begin
      rstn      = 1'b0;
      gen_en    = 1'b1;
      seed_load = 1'b0;
      seed_in   = '0;
      rand_rd   = '0;

      // Reset state
      #1;
      check("rst_ready", 32'(rand_ready), 32'h0);
      check("rst_data", rand_data[31:0] | rand_data[63:32] | rand_data[95:64] | rand_data[127:96], 32'h0);
      check("rst_uflow", 32'(underflow), 32'h0);
      #20 rstn = 1'b1;
      for (int k = 0; k < P; k++) load_model(k, reset_seed(k));
      tick();
      check("rel_ready", 32'(rand_ready), 32'hF);
      for (int k = 0; k < P; k++) check($sformatf("rel_seed%0d", k), data_of(k), exp_q[k][0]);

      // Test 1: seed_load with all seeds = 1
      seed_in   = {P{32'h1}};
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check("t1_flush", 32'(rand_ready), 32'h0);
      tick();
      check("t1_ready", 32'(rand_ready), 32'hF);
      for (int k = 0; k < P; k++) load_model(k, 32'h1);
      check("t1_w0", data_of(0), 32'h00000001);
      pop_cycle(4'b0001, "t1a");
      tick();
      check("t1_w1", data_of(0), 32'h00042021);
      pop_cycle(4'b0001, "t1b");

      // Test 2: fill and hold with no reads
      repeat (6) tick();
      for (int c = 0; c < 100; c++) begin
         for (int k = 0; k < P; k++) check($sformatf("t2_hold%0d", k), data_of(k), exp_q[k][0]);
         tick();
      end
      check("t2_ready", 32'(rand_ready), 32'hF);

      // Test 3: pop every cycle on all ports for 10 cycles
      for (int c = 0; c < 10; c++) pop_cycle(4'b1111, "t3");
      check("t3_ready", 32'(rand_ready), 32'hF);

      // Test 4: refill paused, drain port 0 and read once more
      gen_en = 1'b0;
      for (int c = 0; c < 4; c++) pop_cycle(4'b0001, "t4");
      check("t4_empty", 32'(rand_ready), 32'hE);
      check("t4_uflow0", 32'(underflow), 32'h0);
      rand_rd = 4'b0001;
      tick();
      rand_rd = '0;
      check("t4_uflow1", 32'(underflow), 32'h1);
      tick();
      check("t4_sticky", 32'(underflow), 32'h1);
      check("t4_ready", 32'(rand_ready), 32'hE);

      // Test 5: seed_load together with reads on full ports; port 2 seed is zero
      seed_in   = {32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hDEADBEEF};
      gen_en    = 1'b1;
      seed_load = 1'b1;
      rand_rd   = 4'b1110;
      tick();
      seed_load = 1'b0;
      rand_rd   = '0;
      check("t5_flush", 32'(rand_ready), 32'h0);
      check("t5_uflow", 32'(underflow), 32'h0);
      for (int k = 0; k < P; k++) load_model(k, seed_in[32*k +: 32]);
      tick();
      check("t5_ready", 32'(rand_ready), 32'hF);
      check("t5_p2w0", data_of(2), 32'h00000001);
      for (int c = 0; c < 3; c++) pop_cycle(4'b1111, "t5");
      check("t5_uflow_end", 32'(underflow), 32'h0);

      // Test 6: asynchronous reset mid-stream
      pop_cycle(4'b0101, "t6pre");
      #3 rstn = 1'b0;
      #1;
      check("t6_ready", 32'(rand_ready), 32'h0);
      check("t6_data", rand_data[31:0] | rand_data[63:32] | rand_data[95:64] | rand_data[127:96], 32'h0);
      check("t6_uflow", 32'(underflow), 32'h0);
      #12 rstn = 1'b1;
      for (int k = 0; k < P; k++) load_model(k, reset_seed(k));
      tick();
      check("t6_rel", 32'(rand_ready), 32'hF);
      for (int c = 0; c < 3; c++) pop_cycle(4'b1111, "t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
